// File: rtl/dmux8bit_buffered_if.sv
// Byte-stream bundle for the buffered demux: one valid/ready input stream, two
// valid/ready output channels and per-channel accept counters.
interface dmux8bit_buffered_if #(
  parameter int WIDTH = 8
);
  logic             inValid;
  logic             inReady;
  logic             select;
  logic [WIDTH-1:0] inData;
  logic             outAValid;
  logic             outAReady;
  logic [WIDTH-1:0] outA;
  logic             outBValid;
  logic             outBReady;
  logic [WIDTH-1:0] outB;
  logic [7:0]       countA;
  logic [7:0]       countB;

  modport master (
    output inValid, select, inData, outAReady, outBReady,
    input  inReady, outAValid, outA, outBValid, outB, countA, countB
  );

  modport slave (
    input  inValid, select, inData, outAReady, outBReady,
    output inReady, outAValid, outA, outBValid, outB, countA, countB
  );
endinterface

// File: rtl/dmux8bit_buffered.sv
// Buffered 1:2 byte demultiplexer: each accepted word goes to the FIFO of the
// channel picked by select, so one stalled consumer never drops the other's data.
module dmux8bit_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dmux8bit_buffered_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [WIDTH-1:0] mem_d    [2][DEPTH];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [CW-1:0]    occ_q    [2];
  logic [CW-1:0]    occ_d    [2];
  logic [7:0]       count_q  [2];
  logic [7:0]       count_d  [2];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  assign full[0]   = (occ_q[0] == FULL_OCC);
  assign full[1]   = (occ_q[1] == FULL_OCC);
  assign empty[0]  = (occ_q[0] == '0);
  assign empty[1]  = (occ_q[1] == '0);
  assign out_ready = {bus.outBReady, bus.outAReady};

  // Ready looks only at registered occupancy, so a pop cannot bypass a full FIFO.
  assign bus.inReady = !reset && (bus.select ? !full[1] : !full[0]);
  assign push[0]     = bus.inValid && bus.inReady && !bus.select;
  assign push[1]     = bus.inValid && bus.inReady && bus.select;
  assign pop         = ~empty & out_ready;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = bus.inData;
        wr_ptr_d[c]           = wr_ptr_q[c] + PW'(1);
        count_d[c]            = count_q[c] + 8'd1;
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
      end
      case ({push[c], pop[c]})
        2'b10:   occ_d[c] = occ_q[c] + CW'(1);
        2'b01:   occ_d[c] = occ_q[c] - CW'(1);
        default: occ_d[c] = occ_q[c];
      endcase
    end
  end

  // Storage is not cleared on reset; empty FIFOs force their outputs to zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_ptr_q <= '{default: '0};
      wr_ptr_q <= '{default: '0};
      occ_q    <= '{default: '0};
      count_q  <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

  assign bus.outAValid = !empty[0];
  assign bus.outBValid = !empty[1];
  assign bus.outA      = empty[0] ? '0 : mem_q[0][rd_ptr_q[0]];
  assign bus.outB      = empty[1] ? '0 : mem_q[1][rd_ptr_q[1]];
  assign bus.countA    = count_q[0];
  assign bus.countB    = count_q[1];
endmodule

// File: tb/tb_dmux8bit_buffered.sv
// Self-checking bench for dmux8bit_buffered: a queue-based reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_dmux8bit_buffered;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmux8bit_buffered_if #(.WIDTH(WIDTH)) bus ();

  dmux8bit_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel plus accept counters.
  logic [WIDTH-1:0] qA[$];
  logic [WIDTH-1:0] qB[$];
  int               cntA;
  int               cntB;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                               input logic ra, input logic rb);
    @(posedge clk);
    #1;
    bus.inValid   = v;
    bus.select    = sel;
    bus.inData    = d;
    bus.outAReady = ra;
    bus.outBReady = rb;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    bit accept;
    bit popA;
    bit popB;
    if (reset) begin
      qA.delete();
      qB.delete();
      cntA = 0;
      cntB = 0;
    end else begin
      accept = bus.inValid && (bus.select ? (qB.size() < DEPTH) : (qA.size() < DEPTH));
      popA   = (qA.size() > 0) && bus.outAReady;
      popB   = (qB.size() > 0) && bus.outBReady;
      if (popA) void'(qA.pop_front());
      if (popB) void'(qB.pop_front());
      if (accept && !bus.select) begin
        qA.push_back(bus.inData);
        cntA = (cntA + 1) % 256;
      end
      if (accept && bus.select) begin
        qB.push_back(bus.inData);
        cntB = (cntB + 1) % 256;
      end
    end
  end

  // Every cycle, away from the active edge, compare all outputs to the model.
  always @(negedge clk) begin
    logic expReady;
    expReady = !reset && (bus.select ? (qB.size() < DEPTH) : (qA.size() < DEPTH));
    checkOutput("m_inReady",   32'(bus.inReady),   32'(expReady));
    checkOutput("m_outAValid", 32'(bus.outAValid), 32'(qA.size() > 0));
    checkOutput("m_outBValid", 32'(bus.outBValid), 32'(qB.size() > 0));
    checkOutput("m_outA",      32'(bus.outA),      (qA.size() > 0) ? 32'(qA[0]) : 32'd0);
    checkOutput("m_outB",      32'(bus.outB),      (qB.size() > 0) ? 32'(qB[0]) : 32'd0);
    checkOutput("m_countA",    32'(bus.countA),    32'(cntA));
    checkOutput("m_countB",    32'(bus.countB),    32'(cntB));
  end

  initial begin
    checks        = 0;
    errors        = 0;
    cntA          = 0;
    cntB          = 0;
    reset         = 1'b1;
    bus.inValid   = 1'b1;
    bus.select    = 1'b0;
    bus.inData    = 8'hFF;
    bus.outAReady = 1'b1;
    bus.outBReady = 1'b1;

    $display("[TB] reset with inValid high");
    @(negedge clk);
    checkOutput("rst_inReady_1", 32'(bus.inReady), 32'd0);
    @(negedge clk);
    checkOutput("rst_inReady_2", 32'(bus.inReady), 32'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.inValid = 1'b0;
    @(negedge clk);
    checkOutput("rst_outAValid", 32'(bus.outAValid), 32'd0);
    checkOutput("rst_outBValid", 32'(bus.outBValid), 32'd0);
    checkOutput("rst_outA",      32'(bus.outA),      32'd0);
    checkOutput("rst_countA",    32'(bus.countA),    32'd0);
    checkOutput("rst_inReady",   32'(bus.inReady),   32'd1);

    $display("[TB] routing");
    applyStimulus(1, 0, 8'b10011000, 1, 1);
    applyStimulus(1, 1, 8'b00010010, 1, 1);
    checkOutput("route_outAValid", 32'(bus.outAValid), 32'd1);
    checkOutput("route_outA",      32'(bus.outA),      32'h98);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("route_outA_empty", 32'(bus.outAValid), 32'd0);
    checkOutput("route_outB",       32'(bus.outB),      32'h12);
    checkOutput("route_countA",     32'(bus.countA),    32'd1);
    checkOutput("route_countB",     32'(bus.countB),    32'd1);
    applyStimulus(0, 0, 8'h00, 1, 1);

    $display("[TB] backpressure on A");
    applyStimulus(1, 0, 8'b10101010, 0, 1);
    applyStimulus(1, 0, 8'b01010101, 0, 1);
    applyStimulus(1, 0, 8'b11110000, 0, 1);
    checkOutput("bp_full_inReady", 32'(bus.inReady), 32'd0);
    checkOutput("bp_head",         32'(bus.outA),    32'hAA);
    applyStimulus(1, 1, 8'b00001111, 0, 1);
    checkOutput("bp_B_inReady", 32'(bus.inReady), 32'd1);
    applyStimulus(1, 0, 8'b11110000, 1, 1);
    checkOutput("bp_no_bypass", 32'(bus.inReady), 32'd0);
    checkOutput("bp_outB",      32'(bus.outB),    32'h0F);
    applyStimulus(1, 0, 8'b11110000, 1, 1);
    checkOutput("bp_second",        32'(bus.outA),    32'h55);
    checkOutput("bp_ready_returns", 32'(bus.inReady), 32'd1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("bp_late_word", 32'(bus.outA),   32'hF0);
    checkOutput("bp_countA",    32'(bus.countA), 32'd4);
    checkOutput("bp_countB",    32'(bus.countB), 32'd2);
    applyStimulus(0, 0, 8'h00, 1, 1);

    $display("[TB] simultaneous push and pop");
    applyStimulus(1, 0, 8'h77, 0, 1);
    applyStimulus(1, 0, 8'b00110011, 1, 1);
    checkOutput("pp_head", 32'(bus.outA), 32'h77);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("pp_outA",  32'(bus.outA),      32'h33);
    checkOutput("pp_valid", 32'(bus.outAValid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 8'(8'hA0 + i), 1, 1);
      checkOutput("pp_stream_ready", 32'(bus.inReady), 32'd1);
    end
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("pp_last", 32'(bus.outA), 32'hA7);
    applyStimulus(0, 0, 8'h00, 1, 1);

    $display("[TB] counter wrap on B");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 1, 8'(i), 1, 1);
    end
    applyStimulus(0, 0, 8'h00, 1, 1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("wrap_countB", 32'(bus.countB), 32'd2);
    checkOutput("wrap_countA", 32'(bus.countA), 32'd14);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 0, 8'h11, 0, 0);
    applyStimulus(1, 0, 8'h22, 0, 0);
    applyStimulus(1, 1, 8'h33, 0, 0);
    applyStimulus(1, 1, 8'h44, 0, 0);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.inValid = 1'b0;
    @(negedge clk);
    checkOutput("mid_pre_countB", 32'(bus.countB),  32'd4);
    checkOutput("mid_pre_outB",   32'(bus.outB),    32'h33);
    checkOutput("mid_inReady",    32'(bus.inReady), 32'd0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.outAReady = 1'b1;
    bus.outBReady = 1'b1;
    @(negedge clk);
    checkOutput("mid_outAValid", 32'(bus.outAValid), 32'd0);
    checkOutput("mid_outBValid", 32'(bus.outBValid), 32'd0);
    checkOutput("mid_outB",      32'(bus.outB),      32'd0);
    checkOutput("mid_countA",    32'(bus.countA),    32'd0);
    checkOutput("mid_countB",    32'(bus.countB),    32'd0);
    applyStimulus(0, 0, 8'h00, 1, 1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("mid_never_delivered", 32'(bus.outAValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
